// File: rtl/adc_dac_sequencer_if.sv
// Control, ADC and DAC handshake bundle for adc_dac_sequencer.
// gain_sh is present only when SEQ_GAIN_EN is defined.
interface adc_dac_sequencer_if;
    logic       enable;
    logic       err_clr;
    logic       adc_start;
    logic [9:0] adc_data;
    logic       adc_valid;
    logic       dac_load;
    logic [9:0] dac_data;
    logic [9:0] disp_value;
    logic       disp_strobe;
    logic       busy;
    logic       timeout_err;
    logic       overrun_err;
`ifdef SEQ_GAIN_EN
    logic [1:0] gain_sh;
`endif

    modport master (
        input  enable, err_clr, adc_data, adc_valid,
`ifdef SEQ_GAIN_EN
        input  gain_sh,
`endif
        output adc_start, dac_load, dac_data, disp_value, disp_strobe,
               busy, timeout_err, overrun_err
    );

    modport slave (
        output enable, err_clr, adc_data, adc_valid,
`ifdef SEQ_GAIN_EN
        output gain_sh,
`endif
        input  adc_start, dac_load, dac_data, disp_value, disp_strobe,
               busy, timeout_err, overrun_err
    );
endinterface

// File: rtl/adc_dac_sequencer.sv
// Sample-tick generator that runs one SPI ADC conversion and one DAC write per tick.
// Optional macro SEQ_GAIN_EN adds a saturating left-shift gain on the DAC/display path.
module adc_dac_sequencer #(
    parameter int DIV_N       = 999,
    parameter int ADC_TIMEOUT = 200,
    parameter int DAC_CYC     = 40,
    parameter int DISP_DIV    = 2500
) (
    input  logic                sysclk,
    input  logic                reset,
    adc_dac_sequencer_if.master bus
);
    localparam int DATA_W = 10;
    localparam int TW     = $clog2(DIV_N + 1);
    localparam int WW     = $clog2(ADC_TIMEOUT + 1);
    localparam int DW     = $clog2(DAC_CYC + 1);
    localparam int SW     = $clog2(DISP_DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADC_START,
        ADC_WAIT,
        DAC_LOAD,
        DAC_WAIT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       tcnt;
    logic [WW-1:0]       wd;
    logic [DW-1:0]       dc;
    logic [SW-1:0]       scnt;
    logic [DATA_W-1:0]   dac_word;
    logic [DATA_W-1:0]   disp_word;
    logic                disp_pulse;
    logic                timeout_flag;
    logic                overrun_flag;
    logic                start_pulse;
    logic                load_pulse;
    logic                busy_lvl;
    logic                tick;
    logic                capture;
    logic                to_hit;
    logic [DATA_W-1:0]   smp;

`ifdef SEQ_GAIN_EN
    // Shift is evaluated wide enough for gain 3 so large codes cannot wrap below full scale.
    function automatic logic [DATA_W-1:0] sat_gain(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        sh);
        logic [DATA_W+2:0] w;
        w = {3'b000, d} << sh;
        if (w > {3'b000, {DATA_W{1'b1}}})
            sat_gain = {DATA_W{1'b1}};
        else
            sat_gain = w[DATA_W-1:0];
    endfunction

    assign smp = sat_gain(bus.adc_data, bus.gain_sh);
`else
    assign smp = bus.adc_data;
`endif

    assign tick    = (tcnt == TW'(DIV_N)) && bus.enable;
    assign capture = (state == ADC_WAIT) && bus.adc_valid;
    assign to_hit  = (state == ADC_WAIT) && !bus.adc_valid && (wd == WW'(ADC_TIMEOUT - 1));

    always_ff @(posedge sysclk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_pulse = 1'b0;
        load_pulse  = 1'b0;
        busy_lvl    = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (tick)
                    state_nxt = ADC_START;
            end
            ADC_START: begin
                start_pulse = 1'b1;
                state_nxt   = ADC_WAIT;
            end
            ADC_WAIT: begin
                if (bus.adc_valid)
                    state_nxt = DAC_LOAD;
                else if (wd == WW'(ADC_TIMEOUT - 1))
                    state_nxt = IDLE;
            end
            DAC_LOAD: begin
                load_pulse = 1'b1;
                state_nxt  = DAC_WAIT;
            end
            DAC_WAIT: begin
                if (dc == DW'(DAC_CYC - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // dac_word is loaded on the edge that enters DAC_LOAD, so it is stable for the whole load pulse.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tcnt         <= '0;
            wd           <= '0;
            dc           <= '0;
            scnt         <= '0;
            dac_word     <= '0;
            disp_word    <= '0;
            disp_pulse   <= 1'b0;
            timeout_flag <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            disp_pulse <= 1'b0;

            if (!bus.enable)
                tcnt <= '0;
            else if (tcnt == TW'(DIV_N))
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);

            if (state == ADC_START)
                wd <= '0;
            else if (state == ADC_WAIT)
                wd <= wd + WW'(1);

            if (state == DAC_LOAD)
                dc <= '0;
            else if (state == DAC_WAIT)
                dc <= dc + DW'(1);

            if (capture) begin
                dac_word <= smp;
                if (scnt == SW'(DISP_DIV - 1)) begin
                    scnt       <= '0;
                    disp_word  <= smp;
                    disp_pulse <= 1'b1;
                end else begin
                    scnt <= scnt + SW'(1);
                end
            end

            // Setting takes priority over a simultaneous clear.
            timeout_flag <= to_hit | (timeout_flag & ~bus.err_clr);
            overrun_flag <= (tick & (state != IDLE)) | (overrun_flag & ~bus.err_clr);
        end
    end

    assign bus.adc_start   = start_pulse;
    assign bus.dac_load    = load_pulse;
    assign bus.busy        = busy_lvl;
    assign bus.dac_data    = dac_word;
    assign bus.disp_value  = disp_word;
    assign bus.disp_strobe = disp_pulse;
    assign bus.timeout_err = timeout_flag;
    assign bus.overrun_err = overrun_flag;
endmodule

// File: tb/tb_adc_dac_sequencer.sv
// Randomized bench for adc_dac_sequencer: a transaction-level schedule model predicts every output each cycle.
module tb_adc_dac_sequencer;
    localparam int DIV_N       = 49;
    localparam int ADC_TIMEOUT = 40;
    localparam int DAC_CYC     = 12;
    localparam int DISP_DIV    = 3;
    localparam int NCYC        = 6000;

    logic sysclk = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;
    int   cyc    = 0;

    adc_dac_sequencer_if bus();

    adc_dac_sequencer #(
        .DIV_N      (DIV_N),
        .ADC_TIMEOUT(ADC_TIMEOUT),
        .DAC_CYC    (DAC_CYC),
        .DISP_DIV   (DISP_DIV)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int gained(input int d, input int g);
        int v;
        v = d * (1 << g);
        return (v > 1023) ? 1023 : v;
    endfunction

    initial begin
        int   tph, start_at, valid_at, load_at, free_at, timeout_at, rst_at;
        int   scnt, fate, lat, vdata, gsel, g_valid, pick;
        bit   en, clr, rst, tick, busy_now, chk;
        logic e_start, e_load, e_busy, e_to, e_ov, e_ds;
        logic [9:0] e_data, e_dv;

        tph = 0; start_at = -1; valid_at = -1; load_at = -1; free_at = -1;
        timeout_at = -1; rst_at = -1; scnt = 0; vdata = 0; g_valid = 0; gsel = 0;
        en = 1'b1; chk = 1'b0; tick = 1'b0;
        e_start = 0; e_load = 0; e_busy = 0; e_to = 0; e_ov = 0; e_ds = 0;
        e_data = '0; e_dv = '0;
        reset = 1'b1;
        bus.enable = 1'b0; bus.err_clr = 1'b0; bus.adc_valid = 1'b0; bus.adc_data = '0;
`ifdef SEQ_GAIN_EN
        bus.gain_sh = 2'd0;
`endif

        for (int c = 0; c < NCYC; c++) begin
            @(negedge sysclk);
            cyc = c;
            if (chk) begin
                check_val("adc_start",   16'(bus.adc_start),   16'(e_start));
                check_val("dac_load",    16'(bus.dac_load),    16'(e_load));
                check_val("dac_data",    16'(bus.dac_data),    16'(e_data));
                check_val("busy",        16'(bus.busy),        16'(e_busy));
                check_val("timeout_err", 16'(bus.timeout_err), 16'(e_to));
                check_val("overrun_err", 16'(bus.overrun_err), 16'(e_ov));
                check_val("disp_strobe", 16'(bus.disp_strobe), 16'(e_ds));
                check_val("disp_value",  16'(bus.disp_value),  16'(e_dv));
            end

            // Inputs for this cycle, sampled by the DUT at the next rising edge.
            rst = (c < 3) || (c == rst_at);
            if ($urandom_range(0, 299) == 0) en = !en;
            clr = ($urandom_range(0, 59) == 0);
            gsel = int'($urandom_range(0, 3));
`ifndef SEQ_GAIN_EN
            gsel = 0;
`endif
            reset          = rst;
            bus.enable     = en;
            bus.err_clr    = clr;
            bus.adc_valid  = (c == valid_at);
            bus.adc_data   = (c == valid_at) ? 10'(vdata) : 10'($urandom);
`ifdef SEQ_GAIN_EN
            bus.gain_sh    = 2'(gsel);
`endif
            if (c == valid_at) g_valid = gsel;

            busy_now = e_busy;
            if (rst) begin
                tph = 0; scnt = 0;
                start_at = -1; valid_at = -1; load_at = -1; free_at = -1;
                timeout_at = -1; rst_at = -1;
                e_start = 0; e_load = 0; e_busy = 0; e_to = 0; e_ov = 0; e_ds = 0;
                e_data = '0; e_dv = '0;
            end else begin
                tick = en && (tph == DIV_N);
                tph  = !en ? 0 : ((tph == DIV_N) ? 0 : tph + 1);

                if (tick && !busy_now) begin
                    start_at = c + 1;
                    fate = int'($urandom_range(0, 9));
                    pick = int'($urandom_range(0, 5));
                    case (pick)
                        0: vdata = 'h2A5;
                        1: vdata = 'h0FF;
                        2: vdata = 'h200;
                        3: vdata = 'h3FF;
                        4: vdata = 0;
                        default: vdata = int'($urandom_range(0, 1023));
                    endcase
                    rst_at = -1;
                    if (fate == 0) begin
                        valid_at = -1; load_at = -1;
                        timeout_at = start_at + ADC_TIMEOUT + 1;
                        free_at = timeout_at;
                    end else begin
                        if (fate == 3)      lat = ADC_TIMEOUT;
                        else if (fate == 4) lat = int'($urandom_range(ADC_TIMEOUT - 5, ADC_TIMEOUT));
                        else                lat = int'($urandom_range(1, 30));
                        valid_at = start_at + lat;
                        load_at = valid_at + 1;
                        free_at = load_at + 1 + DAC_CYC;
                        timeout_at = -1;
                        if (fate == 1) rst_at = valid_at;
                        if (fate == 2) rst_at = load_at + 1 + int'($urandom_range(0, DAC_CYC - 1));
                    end
                end

                e_start = ((c + 1) == start_at);
                e_load  = ((c + 1) == load_at);
                e_busy  = (start_at >= 0) && ((c + 1) >= start_at) && ((c + 1) < free_at);
                e_ds    = 1'b0;
                if ((c + 1) == load_at) begin
                    e_data = 10'(gained(vdata, g_valid));
                    scnt++;
                    if (scnt == DISP_DIV) begin
                        scnt = 0;
                        e_ds = 1'b1;
                        e_dv = e_data;
                    end
                end
                e_to = ((c + 1) == timeout_at) || (e_to && !clr);
                e_ov = (tick && busy_now) || (e_ov && !clr);
            end
            chk = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
